tlk2711_tx_framer: RTL and testbench

Transmit-side framer for the TLK2711 serial link, running entirely in the TLK2711 transmit clock domain. It accepts 16-bit payload words on a valid/ready stream with an end-of-frame marker and buffers them in an internal synchronous FIFO. It drives the TLK2711 parallel transmit bus with K-code control: idle fill, SOF, payload, EOF and a minimum inter-frame gap. It is the transmit counterpart of the receive CDC path feeding the link receiver.

---
 rtl/tlk2711_tx_framer.sv | 191 +++++++++++++++++++
 tb/tb_tlk2711_tx_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: buffers 16-bit payload words in a FIFO and drives the
// K-coded TX bus (IDLE/SOF/payload/EOF/gap). Optional macro: TLK2711_TX_CHECKSUM_EN.
module tlk2711_tx_framer #(
  parameter int DATAWIDTH  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int GAP_WORDS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_soft_rst,
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic [15:0]          o_tlk2711_data,
  output logic                 o_tlk2711_tklsb,
  output logic                 o_tlk2711_tkmsb,
  output logic                 o_busy,
  output logic                 o_underrun,
  output logic [15:0]          o_frame_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int GCW = $clog2(GAP_WORDS + 1);
  localparam logic [AW:0]    DEPTH_L  = FIFO_DEPTH[AW:0];
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_WORDS - 1);
  localparam logic [15:0]    W_IDLE   = 16'hC5BC;
  localparam logic [15:0]    W_SOF    = 16'h50FB;
  localparam logic [15:0]    W_EOF    = 16'h50FD;

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_PAYLOAD, S_CSUM, S_EOF, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     pkt_cnt_q, pkt_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]     data_q, data_d;
  logic            tklsb_q, tklsb_d, tkmsb_q, tkmsb_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
`ifdef TLK2711_TX_CHECKSUM_EN
  logic [15:0]     csum_q, csum_d;
`endif

  logic [DATAWIDTH:0] mem [FIFO_DEPTH];
  logic [DATAWIDTH:0] rd_word;
  logic [AW:0]        fill;
  logic               fifo_full, fifo_empty, wr_en, rd_en, wr_last, rd_last;

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fill == DEPTH_L);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign o_ready    = rst_n & ~fifo_full;
  assign wr_en      = i_valid & o_ready;
  assign wr_last    = wr_en & i_last;
  assign rd_word    = mem[rd_ptr_q[AW-1:0]];
  assign rd_last    = rd_en & rd_word[DATAWIDTH];

  // Storage carries the end-of-frame flag alongside each word; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {i_last, i_data};
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = W_IDLE;
    tklsb_d     = 1'b1;
    tkmsb_d     = 1'b0;
    underrun_d  = 1'b0;
    rd_en       = 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Each state chooses the word loaded onto the bus at the coming edge.
    case (state_q)
      S_IDLE: begin
        if (pkt_cnt_q != '0 || fifo_full) begin
          data_d  = W_SOF;
          state_d = S_SOF;
`ifdef TLK2711_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_SOF, S_PAYLOAD: begin
        if (!fifo_empty) begin
          rd_en   = 1'b1;
          data_d  = rd_word[15:0];
          tklsb_d = 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
          csum_d  = csum_q + rd_word[15:0];
          state_d = rd_word[DATAWIDTH] ? S_CSUM : S_PAYLOAD;
`else
          state_d = rd_word[DATAWIDTH] ? S_EOF : S_PAYLOAD;
`endif
        end else begin
          underrun_d = 1'b1;
          state_d    = S_PAYLOAD;
        end
      end
`ifdef TLK2711_TX_CHECKSUM_EN
      S_CSUM: begin
        data_d  = csum_q;
        tklsb_d = 1'b0;
        state_d = S_EOF;
      end
`endif
      S_EOF: begin
        data_d      = W_EOF;
        frame_cnt_d = frame_cnt_q + 16'd1;
        gap_cnt_d   = '0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // Soft reset abandons any frame in flight and empties the buffer.
    if (i_soft_rst) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pkt_cnt_d   = '0;
      gap_cnt_d   = '0;
      frame_cnt_d = '0;
      data_d      = W_IDLE;
      tklsb_d     = 1'b1;
      tkmsb_d     = 1'b0;
      underrun_d  = 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
      csum_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      data_q      <= W_IDLE;
      tklsb_q     <= 1'b1;
      tkmsb_q     <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      tklsb_q     <= tklsb_d;
      tkmsb_q     <= tkmsb_d;
      underrun_q  <= underrun_d;
`ifdef TLK2711_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign o_tlk2711_data  = data_q;
  assign o_tlk2711_tklsb = tklsb_q;
  assign o_tlk2711_tkmsb = tkmsb_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_underrun      = underrun_q;
  assign o_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Scoreboard bench for tlk2711_tx_framer: stimulus pushes the expected bus word
// sequence per frame, a negedge monitor pops and compares against the TX bus.
module tb_tlk2711_tx_framer;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam logic [15:0] K_IDLE = 16'hC5BC;
  localparam logic [15:0] K_SOF  = 16'h50FB;
  localparam logic [15:0] K_EOF  = 16'h50FD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_soft_rst = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready, o_tklsb, o_tkmsb, o_busy, o_underrun;
  logic [15:0] o_data, o_frame_cnt;

  tlk2711_tx_framer #(.DATAWIDTH(16), .FIFO_DEPTH(DEPTH), .GAP_WORDS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .o_tlk2711_data(o_data), .o_tlk2711_tklsb(o_tklsb), .o_tlk2711_tkmsb(o_tkmsb),
    .o_busy(o_busy), .o_underrun(o_underrun), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        k;
    logic        allow_ur;
    logic [15:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   frames_sent = 0;
  bit   mon_en = 1'b0;
  bit   saw_not_ready = 1'b0;

  // Monitor-owned state
  bit   in_frame = 1'b0, seen_eof = 1'b0, allow_cur = 1'b0;
  int   gap_cnt = 0, last_gap = -1, ur_frame = 0, last_frame_ur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: classify each bus word and compare non-idle words against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en || !rst_n) begin
      in_frame = 1'b0;
      seen_eof = 1'b0;
      gap_cnt  = 0;
    end else if (o_data == K_IDLE && o_tklsb && !o_tkmsb) begin
      if (in_frame) begin
        ur_frame++;
        check("midframe_idle_underrun", 32'(o_underrun), 32'd1);
        if (!allow_cur) check("underrun_on_short_frame", 32'(o_underrun), 32'd0);
      end else begin
        gap_cnt++;
        check("idle_underrun_low", 32'(o_underrun), 32'd0);
      end
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_word: got %h k=%0b, required no word", o_data, o_tklsb);
    end else begin
      e = exp_q.pop_front();
      check("bus_data", 32'(o_data), 32'(e.data));
      check("bus_tklsb", 32'(o_tklsb), 32'(e.k));
      check("bus_tkmsb", 32'(o_tkmsb), 32'd0);
      check("word_underrun_low", 32'(o_underrun), 32'd0);
      check("busy_in_frame", 32'(o_busy), 32'd1);
      if (e.k && e.data == K_SOF) begin
        if (seen_eof) check("gap_min", 32'(gap_cnt >= GAP), 32'd1);
        last_gap  = gap_cnt;
        in_frame  = 1'b1;
        ur_frame  = 0;
        allow_cur = e.allow_ur;
      end else if (e.k && e.data == K_EOF) begin
        check("frame_cnt_at_eof", 32'(o_frame_cnt), 32'(e.fcnt));
        in_frame      = 1'b0;
        seen_eof      = 1'b1;
        gap_cnt       = 0;
        last_frame_ur = ur_frame;
        $display("frame %0d done: underrun idles %0d, frame_cnt %0d", e.fcnt, ur_frame, o_frame_cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [15:0] d, input logic l);
    int guard = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    while (!o_ready && guard < 1000) begin
      saw_not_ready = 1'b1;
      tick(1);
      guard++;
    end
    if (guard >= 1000) check("ready_timeout", 32'(o_ready), 32'd1);
    tick(1);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // mode 0: back-to-back writes, 1: random pauses, 2: long stall after DEPTH words
  task automatic send_frame(input int len, input int mode, input bit use_sb);
    logic [15:0] words[$];
    logic [15:0] sum = '0;
    exp_t e;
    for (int i = 0; i < len; i++) begin
      words.push_back(16'($urandom));
      sum += words[i];
    end
    if (use_sb) begin
      frames_sent++;
      e.allow_ur = (len > DEPTH);
      e.fcnt = 16'(frames_sent);
      e.k = 1'b1; e.data = K_SOF; exp_q.push_back(e);
      e.k = 1'b0;
      for (int i = 0; i < len; i++) begin
        e.data = words[i];
        exp_q.push_back(e);
      end
`ifdef TLK2711_TX_CHECKSUM_EN
      e.data = sum; exp_q.push_back(e);
`endif
      e.k = 1'b1; e.data = K_EOF; exp_q.push_back(e);
    end
    $display("send frame len %0d mode %0d checksum %h", len, mode, sum);
    for (int i = 0; i < len; i++) begin
      if (mode == 1 && $urandom_range(3) == 0) tick($urandom_range(1, 3));
      if (mode == 2 && i == DEPTH) tick(12);
      put(words[i], i == len - 1);
    end
  endtask

  task automatic send_fixed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_t e;
    frames_sent++;
    e.allow_ur = 1'b0;
    e.fcnt = 16'(frames_sent);
    e.k = 1'b1; e.data = K_SOF; exp_q.push_back(e);
    e.k = 1'b0;
    e.data = a; exp_q.push_back(e);
    e.data = b; exp_q.push_back(e);
    e.data = c; exp_q.push_back(e);
`ifdef TLK2711_TX_CHECKSUM_EN
    e.data = a + b + c; exp_q.push_back(e);
`endif
    e.k = 1'b1; e.data = K_EOF; exp_q.push_back(e);
    $display("send fixed frame %h %h %h", a, b, c);
    put(a, 1'b0);
    put(b, 1'b0);
    put(c, 1'b1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || o_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_in_time"}, 32'(t < 3000), 32'd1);
    check({name, "_ready_after"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(o_ready), 32'd0);
    check("bus_in_reset", 32'(o_data), 32'(K_IDLE));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_bus", 32'(o_data), 32'(K_IDLE));
      check("reset_tklsb", 32'(o_tklsb), 32'd1);
      check("reset_tkmsb", 32'(o_tkmsb), 32'd0);
      check("reset_ready", 32'(o_ready), 32'd1);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
      check("reset_underrun", 32'(o_underrun), 32'd0);
    end
    mon_en = 1'b1;

    // Single frame 1,2,3
    tick(1);
    send_fixed(16'h0001, 16'h0002, 16'h0003);
    drain("single");
    check("single_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // Back-to-back 2-word frames: exact minimum gap
    send_frame(2, 0, 1'b1);
    send_frame(2, 0, 1'b1);
    drain("b2b");
    check("b2b_gap_exact", 32'(last_gap), 32'(GAP));
    check("b2b_frame_cnt", 32'(o_frame_cnt), 32'd3);

    // Long frame through a full buffer without pauses
    saw_not_ready = 1'b0;
    send_frame(20, 0, 1'b1);
    drain("long");
    check("long_ready_dropped", 32'(saw_not_ready), 32'd1);
    check("long_no_underrun", 32'(last_frame_ur), 32'd0);
    check("long_frame_cnt", 32'(o_frame_cnt), 32'd4);

    // Underrun: input stalls after the buffer fills
    send_frame(12, 2, 1'b1);
    drain("underrun");
    check("underrun_seen", 32'(last_frame_ur > 0), 32'd1);
    check("underrun_frame_cnt", 32'(o_frame_cnt), 32'd5);

    // Randomized frames with random input pauses
    for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 14), 1, 1'b1);
    drain("random");
    check("random_frame_cnt", 32'(o_frame_cnt), 32'(frames_sent));

    // Soft reset mid-frame: no EOF, buffer emptied, counters cleared
    mon_en = 1'b0;
    send_frame(6, 0, 1'b0);
    begin
      int t = 0;
      @(negedge clk);
      while (o_tklsb && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("softrst_reached_payload", 32'(t < 200), 32'd1);
    end
    i_soft_rst = 1'b1;
    tick(1);
    i_soft_rst = 1'b0;
    check("softrst_bus", 32'(o_data), 32'(K_IDLE));
    check("softrst_tklsb", 32'(o_tklsb), 32'd1);
    check("softrst_busy", 32'(o_busy), 32'd0);
    check("softrst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("softrst_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("softrst_idle_bus", 32'(o_data), 32'(K_IDLE));
      check("softrst_idle_busy", 32'(o_busy), 32'd0);
    end
    frames_sent = 0;
    mon_en = 1'b1;

    // Recovery frame after soft reset
    tick(1);
    send_frame(3, 0, 1'b1);
    drain("recover");
    check("recover_frame_cnt", 32'(o_frame_cnt), 32'd1);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
